rst_sequencer: RTL



---
 rtl/rst_sequencer_pkg.sv | 18 +
 rtl/rst_sequencer_sync_2ff.sv | 21 ++
 rtl/rst_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states and rst_cause encodings.
package rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_SOFT = 2'b01,
        CAUSE_LOCK = 2'b10,
        CAUSE_WDT  = 2'b11
    } cause_t;

endpackage

// File: rtl/rst_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Ordered per-subsystem reset release after a filtered PLL lock, with cause logging.
// Optional watchdog reset source enabled by defining RST_SEQ_WDT_EN.
module rst_sequencer
    import rst_pkg::*;
#(
    parameter int unsigned N_STAGES    = 3,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned LOCK_FILTER = 8,
    parameter int unsigned HOLD_CYCLES = 32,
    parameter int unsigned WDT_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_in_n,
    input  logic                pll_locked,
    input  logic                soft_rst_req,
    input  logic                wdt_kick,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                sys_ready,
    output logic [1:0]          rst_cause
);

    localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
    localparam int unsigned DW = $clog2(STAGE_DELAY + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned IW = $clog2(N_STAGES + 1);

    localparam logic [FW-1:0] FILT_TERM = FW'(LOCK_FILTER);
    localparam logic [DW-1:0] DLY_TERM  = DW'(STAGE_DELAY - 1);
    localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

    state_t              state_q, state_d;
    cause_t              cause_q, cause_d, evt_cause;
    logic [FW-1:0]       filt_q, filt_d;
    logic [DW-1:0]       dly_q, dly_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_STAGES-1:0] stage_d;
    logic                ready_d;
    logic                lock_s;
    logic                evt;
    logic                wdt_fire;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_in_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WW = $clog2(WDT_TIMEOUT + 1);
    localparam logic [WW-1:0] WDT_TERM = WW'(WDT_TIMEOUT - 1);

    logic [WW-1:0] wdt_q, wdt_d;

    assign wdt_fire = (state_q == RUN) && !wdt_kick && (wdt_q == WDT_TERM);

    // Counter is zero outside RUN, so RUN entry starts it from a cleared value.
    always_comb begin
        wdt_d = '0;
        if (state_q == RUN && !wdt_kick && !wdt_fire) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    localparam int unsigned unused_wdt_timeout = WDT_TIMEOUT;
    logic unused_wdt_kick;

    assign unused_wdt_kick = wdt_kick;
    assign wdt_fire        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        filt_d    = filt_q;
        dly_d     = dly_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        stage_d   = stage_rst_n;
        ready_d   = sys_ready;
        evt       = 1'b0;
        evt_cause = CAUSE_POR;

        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    filt_d = '0;
                end else if (filt_q == FILT_TERM) begin
                    state_d = RELEASE;
                    filt_d  = '0;
                    dly_d   = '0;
                    idx_d   = '0;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    evt       = 1'b1;
                    evt_cause = CAUSE_LOCK;
                end else if (dly_q == DLY_TERM) begin
                    dly_d   = '0;
                    stage_d = stage_rst_n | (N_STAGES'(1) << idx_q);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    evt       = 1'b1;
                    evt_cause = CAUSE_LOCK;
                end else if (wdt_fire) begin
                    evt       = 1'b1;
                    evt_cause = CAUSE_WDT;
                end else if (soft_rst_req) begin
                    evt       = 1'b1;
                    evt_cause = CAUSE_SOFT;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_TERM) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                    filt_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        // All stages drop together on the event edge, whatever was already released.
        if (evt) begin
            state_d = HOLD;
            cause_d = evt_cause;
            stage_d = '0;
            ready_d = 1'b0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= WAIT_LOCK;
            cause_q     <= CAUSE_POR;
            filt_q      <= '0;
            dly_q       <= '0;
            hold_q      <= '0;
            idx_q       <= '0;
            stage_rst_n <= '0;
            sys_ready   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            filt_q      <= filt_d;
            dly_q       <= dly_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            stage_rst_n <= stage_d;
            sys_ready   <= ready_d;
        end
    end

    assign rst_cause = cause_q;

endmodule
